// File: rtl/cic_interp.sv
// cic_interp: N-stage CIC interpolator with runtime rate R, valid/ready input pacing and sticky underrun.
// Define CIC_INTERP_ROUND_EN for round-half-up output with positive saturation; otherwise truncation.
module cic_interp #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int M             = 2,
  parameter int N             = 5,
  parameter int MAXRATE       = 64,
  parameter int bitgrowth     = 29
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               en_i,
  input  logic [$clog2(MAXRATE+1)-1:0]       rate_i,
  input  logic [DATAIN_WIDTH-1:0]            data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [DATAOUT_WIDTH-1:0]           data_o,
  output logic                               val_o,
  output logic                               underrun_o
);
  localparam int W  = DATAIN_WIDTH + bitgrowth;
  localparam int RW = $clog2(MAXRATE + 1);

  logic [RW-1:0]            cnt_q, rate_q, cnt_d, rate_d;
  logic                     underrun_q, stuff_q, val_q, acc;
  logic [DATAOUT_WIDTH-1:0] data_q, data_d;
  logic [W-1:0]             sampler_q, x;
  logic [W-1:0]             pipe_q   [N];
  logic [W-1:0]             integ_q  [N];
  logic [W-1:0]             dly_q    [N][M];
  logic [W-1:0]             stage_in [N];

  assign ready_o    = cnt_q == '0;
  assign acc        = en_i & ready_o;
  assign cnt_d      = cnt_q == rate_q - RW'(1) ? '0 : cnt_q + RW'(1);
  assign rate_d     = rate_i == '0 ? RW'(1) : rate_i > RW'(MAXRATE) ? RW'(MAXRATE) : rate_i;
  assign x          = valid_i ? {{bitgrowth{data_i[DATAIN_WIDTH-1]}}, data_i} : '0;
  assign data_o     = data_q;
  assign val_o      = val_q;
  assign underrun_o = underrun_q;

  always_comb begin
    stage_in[0] = sampler_q;
    for (int i = 1; i < N; i++) stage_in[i] = pipe_q[i-1];
  end

`ifdef CIC_INTERP_ROUND_EN
  localparam logic [W-1:0] HALF = W'(1) << (bitgrowth - 1);
  logic [W-1:0] rnd;
  assign rnd    = integ_q[N-1] + HALF;
  // Only a positive value can cross the top when adding a positive half-LSB
  assign data_d = (~integ_q[N-1][W-1] & rnd[W-1]) ? {1'b0, {(DATAOUT_WIDTH-1){1'b1}}} : rnd[W-1 -: DATAOUT_WIDTH];
`else
  assign data_d = integ_q[N-1][W-1 -: DATAOUT_WIDTH];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      rate_q     <= RW'(1);
      underrun_q <= 1'b0;
      stuff_q    <= 1'b0;
      val_q      <= 1'b0;
      data_q     <= '0;
      sampler_q  <= '0;
      for (int i = 0; i < N; i++) begin
        pipe_q[i]  <= '0;
        integ_q[i] <= '0;
        for (int j = 0; j < M; j++) dly_q[i][j] <= '0;
      end
    end else begin
      val_q <= en_i;
      if (en_i) begin
        cnt_q      <= cnt_d;
        stuff_q    <= acc;
        data_q     <= data_d;
        if (ready_o) rate_q <= rate_d;
        integ_q[0] <= integ_q[0] + (stuff_q ? pipe_q[N-1] : '0);
        for (int i = 1; i < N; i++) integ_q[i] <= integ_q[i] + integ_q[i-1];
        if (acc) begin
          underrun_q <= underrun_q | ~valid_i;
          sampler_q  <= x;
          for (int i = 0; i < N; i++) begin
            pipe_q[i]   <= stage_in[i] - dly_q[i][M-1];
            dly_q[i][0] <= stage_in[i];
            for (int j = 1; j < M; j++) dly_q[i][j] <= dly_q[i][j-1];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cic_interp.sv
// tb_cic_interp: directed tests for cic_interp (reset, DC gain, rate control, underrun, clock enable).
module tb_cic_interp;
  logic        clk = 1'b0;
  logic        rst_n, en, valid;
  logic [6:0]  rate;
  logic [15:0] din;
  logic        ready, val, und;
  logic [15:0] dout;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cic_interp dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .rate_i(rate), .data_i(din), .valid_i(valid),
    .ready_o(ready), .data_o(dout), .val_o(val), .underrun_o(und)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; valid = 1'b1; rate = 7'd64; din = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_idle: got %b expected 1", ready); end
    en = 1'b1; din = 16'd1000; valid = 1'b0;
    tick();
    valid = 1'b1;
    repeat (1100) tick();
    checks++;
    if (dout !== 16'd1000) begin errors++; $display("FAIL pre_reset_dc: got %0d expected 1000", $signed(dout)); end
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL pre_reset_underrun: got %b expected 1", und); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'd0) begin errors++; $display("FAIL reset_data_o: got %h expected 0000", dout); end
    checks++;
    if (val !== 1'b0) begin errors++; $display("FAIL reset_val_o: got %b expected 0", val); end
    checks++;
    if (und !== 1'b0) begin errors++; $display("FAIL reset_underrun_o: got %b expected 0", und); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %b expected 1", ready); end
    rst_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_dc(input logic [15:0] v);
    int rdy = 0;
    int bad = 0;
    do_reset();
    en = 1'b1; din = v; valid = 1'b1; rate = 7'd64;
    for (int c = 0; c < 1400; c++) begin
      tick();
      if (c >= 200 && c < 840 && ready) rdy++;
      if (c >= 1100 && dout !== v) bad++;
    end
    checks++;
    if (rdy !== 10) begin errors++; $display("FAIL dc_ready_count: got %0d expected 10 in 640 cycles", rdy); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dc_settled_%0d: %0d bad cycles, last %0d expected %0d", $signed(v), bad, $signed(dout), $signed(v)); end
    checks++;
    if (dout !== v) begin errors++; $display("FAIL dc_final: got %h expected %h", dout, v); end
    en = 1'b0;
  endtask

  task automatic test_rate;
    int ones = 0;
    int n;
    do_reset();
    en = 1'b1; rate = 7'd0; din = 16'd0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ready) ones++;
    end
    checks++;
    if (ones !== 10) begin errors++; $display("FAIL rate0_ready: got %0d ready cycles expected 10", ones); end
    rate = 7'd64;
    tick();
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) rate = 7'd32;
    end while (!ready && n < 200);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL rate_period_64: got %0d edges expected 64", n); end
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!ready && n < 200);
      checks++;
      if (n !== 32) begin errors++; $display("FAIL rate_period_32_%0d: got %0d edges expected 32", p, n); end
    end
    en = 1'b0;
  endtask

  task automatic test_underrun;
    int n = 0;
    int bad = 0;
    bit dip = 0;
    do_reset();
    en = 1'b1; din = 16'd1000; valid = 1'b1; rate = 7'd64;
    repeat (1000) tick();
    checks++;
    if (und !== 1'b0) begin errors++; $display("FAIL underrun_idle: got %b expected 0", und); end
    while (!ready && n < 100) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL underrun_wait_ready: got %b expected 1", ready); end
    valid = 1'b0;
    tick();
    valid = 1'b1;
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", und); end
    for (int c = 0; c < 1300; c++) begin
      tick();
      if ($signed(dout) < 16'sd1000) dip = 1;
      if (c >= 1100 && dout !== 16'd1000) bad++;
    end
    checks++;
    if (dip !== 1'b1) begin errors++; $display("FAIL underrun_dip: got %b expected a dip below 1000", dip); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL underrun_recover: %0d bad cycles, last %0d expected 1000", bad, $signed(dout)); end
    checks++;
    if (und !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", und); end
    en = 1'b0;
  endtask

  task automatic test_en_toggle;
    int badv = 0;
    int badh = 0;
    int bads = 0;
    logic pe;
    logic [15:0] prev;
    do_reset();
    din = 16'd1000; valid = 1'b1; rate = 7'd64;
    for (int c = 0; c < 2800; c++) begin
      en = (c % 2) == 0;
      pe = en;
      prev = dout;
      tick();
      if (val !== pe) badv++;
      if (!pe && dout !== prev) badh++;
      if (c >= 2400 && pe && dout !== 16'd1000) bads++;
    end
    checks++;
    if (badv !== 0) begin errors++; $display("FAIL en_val_follow: %0d cycles where val_o differed from previous en_i", badv); end
    checks++;
    if (badh !== 0) begin errors++; $display("FAIL en_hold: %0d cycles where data_o changed with en_i=0", badh); end
    checks++;
    if (bads !== 0) begin errors++; $display("FAIL en_settled: %0d bad edges, last %0d expected 1000", bads, $signed(dout)); end
    en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dc(16'd1000);
    test_dc(16'hFC18);
    test_rate();
    test_underrun();
    test_en_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
